// File: rtl/day10_down_timer.sv
// Loadable down-counter with terminal-count pulse, auto-reload
// and a wrapping terminal-count event counter.
module day10_down_timer #(
  parameter int WIDTH = 4,
  parameter int TCW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             load_ready_o,
  input  logic             pause_i,
  input  logic             reload_en_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic [TCW-1:0]   tc_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic [TCW-1:0]   tc_q, tc_d;
  logic             hs;

  assign load_ready_o = (state_q == IDLE) && reset;
  assign hs           = load_valid_i && load_ready_o;
  assign busy_o       = (state_q != IDLE);
  assign tc_o         = (state_q == DONE);
  assign count_o      = cnt_q;
  assign tc_cnt_o     = tc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = tc_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          cnt_d   = load_val_i;
          rld_d   = load_val_i;
          state_d = (load_val_i != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!pause_i) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == WIDTH'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        // The event counts even when aborted out of DONE.
        tc_d = tc_q + 1'b1;
        if (abort_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (reload_en_i) begin
          cnt_d   = rld_q;
          state_d = (rld_q != '0) ? COUNT : DONE;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

endmodule

// File: tb/tb_day10_down_timer.sv
// Directed test of day10_down_timer with
// hand-computed expected values.
module tb_day10_down_timer;

  logic       clk;
  logic       reset;
  logic       load_valid_i;
  logic [3:0] load_val_i;
  logic       load_ready_o;
  logic       pause_i;
  logic       reload_en_i;
  logic       abort_i;
  logic [3:0] count_o;
  logic       busy_o;
  logic       tc_o;
  logic [7:0] tc_cnt_o;

  int n_chk;
  int n_fail;

  day10_down_timer #(.WIDTH(4), .TCW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load_valid_i),
    .load_val_i   (load_val_i),
    .load_ready_o (load_ready_o),
    .pause_i      (pause_i),
    .reload_en_i  (reload_en_i),
    .abort_i      (abort_i),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .tc_o         (tc_o),
    .tc_cnt_o     (tc_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    chk("ld_ready", load_ready_o, 1);
    load_valid_i = 1'b1;
    load_val_i   = v;
    step();
    load_valid_i = 1'b0;
    chk("ld_cnt", count_o, v);
  endtask

  initial begin
    int n;
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    load_valid_i = 1'b1;
    load_val_i = 4'd7;
    pause_i = 1'b0;
    reload_en_i = 1'b0;
    abort_i = 1'b0;

    step();
    step();
    chk("rst_ready", load_ready_o, 0);
    chk("rst_cnt", count_o, 0);
    chk("rst_tccnt", tc_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tc", tc_o, 0);
    load_valid_i = 1'b0;
    reset = 1'b1;
    step();
    chk("idle_busy", busy_o, 0);

    // one-shot load 5
    load(4'd5);
    chk("os_busy", busy_o, 1);
    for (int i = 4; i >= 0; i--) begin
      step();
      chk("os_cnt", count_o, i);
      chk("os_tc", tc_o, (i == 0) ? 1 : 0);
    end
    step();
    chk("os_idle", busy_o, 0);
    chk("os_tc_lo", tc_o, 0);
    chk("os_tccnt", tc_cnt_o, 1);

    // pause 3 cycles at count 2
    load(4'd4);
    step();
    step();
    chk("pa_cnt2", count_o, 2);
    pause_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pa_hold", count_o, 2);
      chk("pa_tc", tc_o, 0);
    end
    pause_i = 1'b0;
    step();
    chk("pa_cnt1", count_o, 1);
    chk("pa_tc1", tc_o, 0);
    step();
    chk("pa_cnt0", count_o, 0);
    chk("pa_tc0", tc_o, 1);
    step();
    chk("pa_tccnt", tc_cnt_o, 2);

    // abort at count 3
    load(4'd4);
    step();
    chk("ab_cnt3", count_o, 3);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("ab_busy", busy_o, 0);
    chk("ab_cnt", count_o, 0);
    chk("ab_tc", tc_o, 0);
    step();
    chk("ab_tc2", tc_o, 0);
    chk("ab_tccnt", tc_cnt_o, 2);

    // auto-reload of 3, ten periods
    reload_en_i = 1'b1;
    load(4'd3);
    for (int p = 0; p < 10; p++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        chk("ar_tc", tc_o, (j == 2) ? 1 : 0);
      end
      if (p == 9)
        reload_en_i = 1'b0;
      step();
      if (p < 9)
        chk("ar_rld", count_o, 3);
    end
    chk("ar_idle", busy_o, 0);
    chk("ar_tccnt", tc_cnt_o, 12);

    // load 0
    load(4'd0);
    chk("z_tc", tc_o, 1);
    step();
    chk("z_tc_lo", tc_o, 0);
    chk("z_tccnt", tc_cnt_o, 13);

    // load 0 with reload: continuous tc
    reload_en_i = 1'b1;
    load(4'd0);
    chk("zr_tc", tc_o, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zr_tc", tc_o, 1);
    end
    reload_en_i = 1'b0;
    step();
    chk("zr_idle", busy_o, 0);
    chk("zr_tccnt", tc_cnt_o, 18);

    // load 15: tc 15 edges after load edge
    load(4'd15);
    n = 0;
    do begin
      step();
      n++;
    end while (!tc_o && n < 20);
    chk("l15_lat", n, 15);
    chk("l15_tc", tc_o, 1);
    step();
    chk("l15_tccnt", tc_cnt_o, 19);

    // abort in DONE with reload set
    reload_en_i = 1'b1;
    load(4'd1);
    step();
    chk("ad_tc", tc_o, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    reload_en_i = 1'b0;
    chk("ad_busy", busy_o, 0);
    chk("ad_cnt", count_o, 0);
    chk("ad_tccnt", tc_cnt_o, 20);

    // wrap: 236 more DONE cycles reach 256 total
    reload_en_i = 1'b1;
    load(4'd0);
    repeat (235) step();
    chk("wr_pre", tc_cnt_o, 255);
    reload_en_i = 1'b0;
    step();
    chk("wr_tccnt", tc_cnt_o, 0);
    chk("wr_idle", busy_o, 0);

    // back-to-back: held load_valid
    load_valid_i = 1'b1;
    load_val_i = 4'd2;
    step();
    chk("bb_cnt2", count_o, 2);
    step();
    step();
    chk("bb_tc", tc_o, 1);
    step();
    chk("bb_idle", busy_o, 0);
    chk("bb_ready", load_ready_o, 1);
    step();
    chk("bb_reld", count_o, 2);
    chk("bb_busy", busy_o, 1);
    load_valid_i = 1'b0;
    step();
    chk("bb_cnt1", count_o, 1);

    // reset mid-count
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rm_busy", busy_o, 0);
    chk("rm_cnt", count_o, 0);
    chk("rm_tccnt", tc_cnt_o, 0);
    step();
    chk("rm_tc", tc_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
